// File: rtl/pm_fetch_responder_pkg.sv
// Shared constants for the program-memory fetch responder and sequencer decode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pm_fetch_responder_pkg;

   // Boot/run phases of the responder
   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_REL  = 2'd1,
      ST_RUN  = 2'd2
   } pm_state_t;

   // Opcode presented while the sequencer is held in reset or on a bad fetch
   localparam logic [31:0] PM_NOP = 32'h0000_0000;

   // Idle opcode recognised by the sequencer decode (bits 31:23 = 1)
   localparam logic [31:0] PM_IDLE_OP = {9'd1, 23'd0};

endpackage

// File: rtl/pm_fetch_responder_sram.sv
// Instruction store: one synchronous write port (loader), one synchronous read port (fetch).
// Latency: read data registered one cycle after raddr is sampled with re; holds when re=0.
// Backpressure: none; contents are never reset.
module pm_sram_1r1w
   import pm_fetch_responder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Loader write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Fetch read port; the output register holds between fetches
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/pm_fetch_responder.sv
// Program-memory responder: boot-loads the store, releases sequencer reset, serves fetches.
// Latency: fetch opcode valid one cycle after the address edge; release two edges after last load.
// Backpressure: ld_ready high only in LOAD (state decode, independent of ld_valid).
module pm_fetch_responder
   import pm_fetch_responder_pkg::*;
#(
   parameter int PM_DEPTH = 256,
   parameter int PM_AW    = 16,
   parameter int PM_DW    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ps_pm_cslt,
   input  logic             ps_pm_wrb,
   input  logic [PM_AW-1:0] ps_pm_add,
   output logic [PM_DW-1:0] pm_ps_op,
   output logic             pm_ps_rst_n,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [PM_DW-1:0] ld_data,
   input  logic             ld_last,
   output logic             pm_boot_done,
   output logic             pm_err_oor,
   output logic             pm_err_wr
);

   localparam int IW = (PM_DEPTH > 1) ? $clog2(PM_DEPTH) : 1;

   pm_state_t        state;
   pm_state_t        state_nxt;
   logic [IW-1:0]    ld_cnt;
   logic             ld_acc;
   logic             ld_end;
   logic             fetch_en;
   logic             fetch_oor;
   logic             fetch_rd;
   logic             op_zero;
   logic [PM_DW-1:0] rd_dat;

   assign ld_acc    = ld_valid && ld_ready;
   // Leave LOAD on an explicit last word or once the final slot is written
   assign ld_end    = ld_acc && (ld_last || (ld_cnt == IW'(PM_DEPTH - 1)));
   // Extra MSB so a depth of 65536 still compares correctly against a 16-bit address
   assign fetch_oor = ({1'b0, ps_pm_add} >= (PM_AW + 1)'(PM_DEPTH));
   assign fetch_en  = (state == ST_RUN) && ps_pm_cslt;
   assign fetch_rd  = fetch_en && !fetch_oor;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_LOAD;
      else     state <= state_nxt;
   end

   // Next-state logic: LOAD -> REL (one cycle) -> RUN until reset
   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOAD: if (ld_end) state_nxt = ST_REL;
         ST_REL:  state_nxt = ST_RUN;
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_LOAD;
      endcase
   end

   // State decode outputs; sequencer reset stays asserted through REL
   always_comb begin
      ld_ready     = 1'b0;
      pm_ps_rst_n  = 1'b0;
      pm_boot_done = 1'b0;
      case (state)
         ST_LOAD: ld_ready = 1'b1;
         ST_RUN: begin
            pm_ps_rst_n  = 1'b1;
            pm_boot_done = 1'b1;
         end
         default: ;
      endcase
   end

   // Loader write pointer, restarts at zero on every reset
   always_ff @(posedge clk) begin
      if (rst)         ld_cnt <= '0;
      else if (ld_acc) ld_cnt <= ld_cnt + 1'b1;
   end

   // Zero-select for the opcode: forced outside RUN and on out-of-range fetch, held when idle
   always_ff @(posedge clk) begin
      if (rst)                  op_zero <= 1'b1;
      else if (state != ST_RUN) op_zero <= 1'b1;
      else if (fetch_en)        op_zero <= fetch_oor;
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pm_err_oor <= 1'b0;
         pm_err_wr  <= 1'b0;
      end else begin
         if (fetch_en && fetch_oor)  pm_err_oor <= 1'b1;
         if (fetch_en && ps_pm_wrb)  pm_err_wr  <= 1'b1;
      end
   end

   pm_sram_1r1w #(
      .DEPTH (PM_DEPTH),
      .AW    (IW),
      .DW    (PM_DW)
   ) u_sram (
      .clk   (clk),
      .we    (ld_acc),
      .waddr (ld_cnt),
      .wdata (ld_data),
      .re    (fetch_rd),
      .raddr (ps_pm_add[IW-1:0]),
      .rdata (rd_dat)
   );

   // Both select and data are flops, so the opcode stays a registered value
   assign pm_ps_op = op_zero ? PM_DW'(PM_NOP) : rd_dat;

endmodule

// File: tb/tb_pm_fetch_responder.sv
// Self-checking bench for pm_fetch_responder: directed loads/fetches plus a cycle model.
// Latency: model predicts outputs after each clk edge; compared on the falling edge.
// Backpressure: loader driven every cycle; acceptance predicted from boot phase.
module tb_pm_fetch_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ps_pm_cslt = 1'b0;
   logic        ps_pm_wrb = 1'b0;
   logic [15:0] ps_pm_add = 16'd0;
   logic [31:0] pm_ps_op;
   logic        pm_ps_rst_n;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [31:0] ld_data = 32'd0;
   logic        ld_last = 1'b0;
   logic        pm_boot_done;
   logic        pm_err_oor;
   logic        pm_err_wr;

   int tests = 0;
   int failed = 0;

   always #5 clk = ~clk;

   pm_fetch_responder #(
      .PM_DEPTH (256),
      .PM_AW    (16),
      .PM_DW    (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ps_pm_cslt   (ps_pm_cslt),
      .ps_pm_wrb    (ps_pm_wrb),
      .ps_pm_add    (ps_pm_add),
      .pm_ps_op     (pm_ps_op),
      .pm_ps_rst_n  (pm_ps_rst_n),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_data      (ld_data),
      .ld_last      (ld_last),
      .pm_boot_done (pm_boot_done),
      .pm_err_oor   (pm_err_oor),
      .pm_err_wr    (pm_err_wr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // boot_ago: -1 while loading, else edges since the final word was accepted
   int          boot_ago = -1;
   int          cnt_m = 0;
   logic [31:0] mem_m [256];
   bit          mem_v [256];
   logic [31:0] exp_op = 32'd0;
   bit          op_known = 1'b1;
   bit          exp_oor = 1'b0;
   bit          exp_wr = 1'b0;
   bit          started = 1'b0;

   always @(posedge clk) begin
      bit run_before;
      if (rst) begin
         boot_ago = -1;
         cnt_m    = 0;
         exp_op   = 32'd0;
         op_known = 1'b1;
         exp_oor  = 1'b0;
         exp_wr   = 1'b0;
         started  = 1'b1;
      end else if (started) begin
         run_before = (boot_ago >= 1);
         if (boot_ago >= 0) begin
            if (boot_ago < 3) boot_ago++;
         end else if (ld_valid) begin
            mem_m[cnt_m] = ld_data;
            mem_v[cnt_m] = 1'b1;
            if (ld_last || cnt_m == 255) boot_ago = 0;
            else cnt_m++;
         end
         if (!run_before) begin
            exp_op   = 32'd0;
            op_known = 1'b1;
         end else if (ps_pm_cslt) begin
            if (ps_pm_add >= 16'd256) begin
               exp_op   = 32'd0;
               op_known = 1'b1;
               exp_oor  = 1'b1;
            end else begin
               exp_op   = mem_m[ps_pm_add[7:0]];
               op_known = mem_v[ps_pm_add[7:0]];
            end
            if (ps_pm_wrb) exp_wr = 1'b1;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         chk1("m_ld_ready", ld_ready, boot_ago < 0);
         chk1("m_rst_n", pm_ps_rst_n, boot_ago >= 1);
         chk1("m_boot_done", pm_boot_done, boot_ago >= 1);
         chk1("m_err_oor", pm_err_oor, exp_oor);
         chk1("m_err_wr", pm_err_wr, exp_wr);
         if (op_known) chk("m_op", pm_ps_op, exp_op);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic pulse_rst();
      ps_pm_cslt = 1'b0;
      ps_pm_wrb  = 1'b0;
      ld_valid   = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic fetch(input logic [15:0] a, input logic w);
      ps_pm_cslt = 1'b1;
      ps_pm_add  = a;
      ps_pm_wrb  = w;
      step();
   endtask

   initial begin
      logic [31:0] w;
      repeat (2) step();
      chk("rst_op", pm_ps_op, 32'h0);
      chk1("rst_rst_n", pm_ps_rst_n, 1'b0);
      chk1("rst_ld_ready", ld_ready, 1'b1);
      chk1("rst_boot_done", pm_boot_done, 1'b0);
      rst = 1'b0;

      // Four-word load with ld_last on the fourth
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1;
         ld_data  = 32'h1111_1111 * 32'(i + 1);
         ld_last  = (i == 3);
         step();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      chk1("t1_ld_ready_low", ld_ready, 1'b0);
      chk1("t1_rst_n_rel", pm_ps_rst_n, 1'b0);
      step();
      chk1("t1_rst_n_run", pm_ps_rst_n, 1'b1);
      chk1("t1_boot_done", pm_boot_done, 1'b1);
      for (int i = 0; i < 4; i++) begin
         fetch(16'(i), 1'b0);
         w = 32'h1111_1111 * 32'(i + 1);
         chk("t1_fetch", pm_ps_op, w);
      end

      // Out-of-range fetch, then the flag stays set on a good fetch
      fetch(16'h0100, 1'b0);
      chk("t3_oor_op", pm_ps_op, 32'h0);
      chk1("t3_oor_flag", pm_err_oor, 1'b1);
      fetch(16'd1, 1'b0);
      chk("t3_after_op", pm_ps_op, 32'h2222_2222);
      chk1("t3_oor_sticky", pm_err_oor, 1'b1);

      // Write-strobe fetch reads and leaves memory intact
      fetch(16'd2, 1'b1);
      chk("t4_wr_op", pm_ps_op, 32'h3333_3333);
      chk1("t4_wr_flag", pm_err_wr, 1'b1);
      fetch(16'd2, 1'b0);
      chk("t4_reread", pm_ps_op, 32'h3333_3333);

      // Loader word in RUN is ignored
      ld_valid = 1'b1;
      ld_data  = 32'hDEAD_0000;
      fetch(16'd0, 1'b0);
      ld_valid = 1'b0;
      fetch(16'd0, 1'b0);
      chk("t4_run_ld_ignored", pm_ps_op, 32'h1111_1111);

      // Reset clears flags; reset again mid-load and reload
      pulse_rst();
      chk1("t6_oor_clr", pm_err_oor, 1'b0);
      chk1("t6_wr_clr", pm_err_wr, 1'b0);
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1'b1;
         ld_data  = 32'hA000_0000 + 32'(i);
         step();
      end
      pulse_rst();
      chk("t6_op", pm_ps_op, 32'h0);
      chk1("t6_rst_n", pm_ps_rst_n, 1'b0);
      chk1("t6_ld_ready", ld_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1;
         ld_data  = 32'hB000_0000 + 32'(i);
         ld_last  = (i == 3);
         step();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      step();
      fetch(16'd0, 1'b0);
      chk("t6_new0", pm_ps_op, 32'hB000_0000);
      fetch(16'd3, 1'b0);
      chk("t6_new3", pm_ps_op, 32'hB000_0003);

      // Fill the whole store without ld_last
      pulse_rst();
      for (int i = 0; i < 256; i++) begin
         ld_valid = 1'b1;
         ld_data  = 32'hC000_0000 + 32'(i);
         ld_last  = 1'b0;
         step();
      end
      chk1("t2_full_ready", ld_ready, 1'b0);
      ld_data = 32'hDEAD_BEEF;
      ld_last = 1'b1;
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      chk1("t2_rst_n", pm_ps_rst_n, 1'b1);
      fetch(16'd0, 1'b0);
      chk("t2_word0", pm_ps_op, 32'hC000_0000);
      fetch(16'd255, 1'b0);
      chk("t2_word255", pm_ps_op, 32'hC000_00FF);

      // Idle holds the last opcode
      fetch(16'd5, 1'b0);
      chk("t5_fetch5", pm_ps_op, 32'hC000_0005);
      ps_pm_cslt = 1'b0;
      ps_pm_add  = 16'd7;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_idle_hold", pm_ps_op, 32'hC000_0005);
      end

      step();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/pm_fetch_responder.md
# pm_fetch_responder

Program-memory responder for the program sequencer's instruction-fetch port. Holds the instruction store, answers every fetch with a registered 32-bit opcode one cycle after the address, and runs a boot-load phase that fills the store from an external loader before holding the sequencer in reset and then releasing it. Sits between the loader/host and the sequencer, driving the sequencer's `pm_ps_op` and its active-low reset.

## Interface
- `PM_DEPTH`, 256: instruction words stored; power of two, at most 65536.
- `PM_AW`, 16: fetch address width; matches `ps_pm_add`.
- `PM_DW`, 32: instruction width.
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `ps_pm_cslt`  in  1  fetch chip-select from sequencer.
- `ps_pm_wrb`  in  1  write strobe from sequencer; unsupported, flagged.
- `ps_pm_add`  in  16  fetch address.
- `pm_ps_op`  out  32  fetched instruction, registered.
- `pm_ps_rst_n`  out  1  active-low reset to the sequencer.
- `ld_valid`  in  1  loader word valid.
- `ld_ready`  out  1  responder accepts a loader word.
- `ld_data`  in  32  loader instruction word.
- `ld_last`  in  1  marks the final loader word.
- `pm_boot_done`  out  1  high once in RUN.
- `pm_err_oor`  out  1  sticky: fetch address ≥ `PM_DEPTH`.
- `pm_err_wr`  out  1  sticky: fetch with `ps_pm_wrb`=1.

## Operation
- FSM states:
  - LOAD: entered on reset.
    - `ld_ready`=1.
    - A word is accepted when `ld_valid`&`ld_ready`. It is written to `mem[ld_cnt]` and `ld_cnt` increments.
    - Exit to REL when the accepted word has `ld_last`=1, or when `ld_cnt`==`PM_DEPTH`-1 at acceptance (store full). Further loader words are not accepted.
  - REL: lasts one cycle.
    - `ld_ready`=0.
    - `pm_ps_rst_n` is still 0, so the sequencer sees reset asserted for at least one full edge after the last write.
    - Next state is RUN.
  - RUN:
    - `pm_ps_rst_n`=1, `pm_boot_done`=1, `ld_ready`=0.
    - Stays in RUN until `rst`.
- Fetch in RUN, evaluated on each clk edge:
  - If `ps_pm_cslt`=1 and the address is in range: `pm_ps_op` ← `mem[ps_pm_add[log2(PM_DEPTH)-1:0]]`.
  - If `ps_pm_cslt`=1 and `ps_pm_add` ≥ `PM_DEPTH`: `pm_ps_op` ← 0 and `pm_err_oor` ← 1.
  - If `ps_pm_wrb`=1 with `cslt`: no memory write, the read still occurs, and `pm_err_wr` ← 1.
  - If `ps_pm_cslt`=0 (sequencer idle): `pm_ps_op` holds its last value, so the idle opcode stays presented.
- In LOAD and REL, `pm_ps_op` is forced to 0 (NOP encoding) and fetch inputs are ignored.
- Loader words arriving in RUN are ignored: not accepted, no write.
- Words never loaded read back as whatever the memory previously held. The store is not cleared by `rst`.

## Timing
- Reset values (cycle after `rst` sampled high):
  - `pm_ps_op`=0, `pm_ps_rst_n`=0, `ld_ready`=1, `pm_boot_done`=0, `pm_err_oor`=0, `pm_err_wr`=0.
  - `ld_cnt`=0, state LOAD.
- Fetch latency is one cycle. The address is sampled at edge n and `pm_ps_op` is valid after edge n, aligned with the sequencer's decode-address stage.
- Loader throughput is one word per cycle. `ld_ready` is a registered state decode and does not depend on `ld_valid`.
- Release:
  - The last word is accepted at edge k.
  - REL holds for cycle k..k+1.
  - `pm_ps_rst_n`=1 and `pm_boot_done`=1 after edge k+1.
  - The first sequencer fetch (address 0) is sampled at edge k+2, so `pm_ps_op`=`mem[0]` after edge k+2.
- `rst` mid-load or mid-run:
  - Immediate return to LOAD with `ld_cnt`=0 and outputs at reset values.
  - Sticky flags clear.
  - Memory contents are retained.
- Sticky error flags clear only on `rst`.

## Structure
- Shared package holds:
  - state encoding constants LOAD=2'd0, REL=2'd1, RUN=2'd2;
  - `PM_NOP`=32'h0;
  - the idle-opcode constant (bits 31:23 = 9'd1), shared with the sequencer decode.
- Sub-module `pm_sram_1r1w`: single-clock array with one synchronous write port (loader) and one synchronous read port (fetch). No reset on contents.
- Top level holds the FSM, `ld_cnt`, the address range check, the output mux to 0, and the error flags.

## Test plan
- Load 4 words 32'h11111111..32'h44444444 with `ld_last` on the 4th -> `ld_ready`=0 in the cycle after; `pm_ps_rst_n` rises 2 edges after the last accept; fetch addr 0..3 returns the words 1 cycle later in order.
- Fill `PM_DEPTH`=256 without `ld_last` -> FSM leaves LOAD at word 256; a 257th `ld_valid` is not accepted; fetch 255 returns word 255.
- In RUN, fetch `ps_pm_add`=16'h0100 with `PM_DEPTH`=256 -> `pm_ps_op`=0 and `pm_err_oor`=1, which stays 1 on later valid fetches.
- In RUN, fetch with `ps_pm_wrb`=1 at addr 2 -> `pm_ps_op`=`mem[2]`, memory unchanged on re-read, `pm_err_wr`=1.
- Drop `ps_pm_cslt` for 3 cycles after fetching addr 5 -> `pm_ps_op` holds `mem[5]` for all 3 cycles.
- Assert `rst` after loading 2 of 4 words -> state LOAD, `ld_cnt`=0, `pm_ps_op`=0, `pm_ps_rst_n`=0; reload 4 new words, then a fetch returns the new values.
